// File: rtl/mem_arbiter.sv
// Two-port (CPU/DMA) round-robin arbiter in front of a single synchronous byte memory.
// One access at a time: IDLE -> ACCESS -> [WAIT xN] -> DONE -> IDLE.
module mem_arbiter #(
  parameter int unsigned WAIT = 0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        c_req,
  input  logic        c_wren,
  input  logic [15:0] c_address,
  input  logic [7:0]  c_data,
  output logic        c_ready,
  output logic [7:0]  c_rdata,
  input  logic        d_req,
  input  logic        d_wren,
  input  logic [15:0] d_address,
  input  logic [7:0]  d_data,
  output logic        d_ready,
  output logic [7:0]  d_rdata,
  output logic [15:0] m_address,
  output logic [7:0]  m_o_data,
  output logic        m_wren,
  input  logic [7:0]  m_i_data
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WAIT, S_DONE} state_e;

  localparam logic [2:0] WAIT_LD = 3'(WAIT);

  state_e     state_q;
  logic       gnt_q;    // current grantee: 0 = CPU, 1 = DMA
  logic       last_q;   // last grantee, same encoding
  logic       wr_q;
  logic [2:0] cnt_q;

  logic pick_dma_d;
  logic to_done_d;

  // DMA wins only when alone or when the CPU had the previous grant.
  assign pick_dma_d = d_req && (!c_req || !last_q);
  assign to_done_d  = (state_q == S_ACCESS && WAIT == 0) ||
                      (state_q == S_WAIT && cnt_q == 3'd1);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      gnt_q     <= 1'b0;
      last_q    <= 1'b1;
      wr_q      <= 1'b0;
      cnt_q     <= 3'd0;
      m_address <= 16'h0000;
      m_o_data  <= 8'h00;
      m_wren    <= 1'b0;
      c_ready   <= 1'b0;
      d_ready   <= 1'b0;
      c_rdata   <= 8'h00;
      d_rdata   <= 8'h00;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (c_req || d_req) begin
            gnt_q     <= pick_dma_d;
            last_q    <= pick_dma_d;
            m_address <= pick_dma_d ? d_address : c_address;
            m_o_data  <= pick_dma_d ? d_data    : c_data;
            wr_q      <= pick_dma_d ? d_wren    : c_wren;
            m_wren    <= pick_dma_d ? d_wren    : c_wren;
            state_q   <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          m_wren <= 1'b0;
          if (WAIT == 0) begin
            state_q <= S_DONE;
          end else begin
            cnt_q   <= WAIT_LD;
            state_q <= S_WAIT;
          end
        end
        S_WAIT: begin
          cnt_q <= cnt_q - 3'd1;
          if (cnt_q == 3'd1) state_q <= S_DONE;
        end
        S_DONE: begin
          c_ready <= 1'b0;
          d_ready <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase

      // Read data is valid on the edge that enters DONE; writes leave rdata alone.
      if (to_done_d) begin
        if (gnt_q) begin
          d_ready <= 1'b1;
          if (!wr_q) d_rdata <= m_i_data;
        end else begin
          c_ready <= 1'b1;
          if (!wr_q) c_rdata <= m_i_data;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench: dut0 (WAIT=0) and dut3 (WAIT=3) share stimulus; each task checks one scenario.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        c_req = 1'b0, c_wren = 1'b0, d_req = 1'b0, d_wren = 1'b0;
  logic [15:0] c_address = 16'h0, d_address = 16'h0;
  logic [7:0]  c_data = 8'h0, d_data = 8'h0;

  logic        c_ready0, d_ready0, m_wren0, c_ready3, d_ready3, m_wren3;
  logic [7:0]  c_rdata0, d_rdata0, m_o_data0, m_i_data0;
  logic [7:0]  c_rdata3, d_rdata3, m_o_data3, m_i_data3;
  logic [15:0] m_address0, m_address3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Memory contents: a fixed pattern, with 0x1234 holding 0xA5.
  function automatic logic [7:0] memfn(input logic [15:0] a);
    if (a == 16'h1234) return 8'hA5;
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  assign m_i_data0 = memfn(m_address0);
  assign m_i_data3 = memfn(m_address3);

  mem_arbiter #(.WAIT(0)) dut0 (
    .clock(clk), .reset(reset),
    .c_req(c_req), .c_wren(c_wren), .c_address(c_address), .c_data(c_data),
    .c_ready(c_ready0), .c_rdata(c_rdata0),
    .d_req(d_req), .d_wren(d_wren), .d_address(d_address), .d_data(d_data),
    .d_ready(d_ready0), .d_rdata(d_rdata0),
    .m_address(m_address0), .m_o_data(m_o_data0), .m_wren(m_wren0), .m_i_data(m_i_data0)
  );

  mem_arbiter #(.WAIT(3)) dut3 (
    .clock(clk), .reset(reset),
    .c_req(c_req), .c_wren(c_wren), .c_address(c_address), .c_data(c_data),
    .c_ready(c_ready3), .c_rdata(c_rdata3),
    .d_req(d_req), .d_wren(d_wren), .d_address(d_address), .d_data(d_data),
    .d_ready(d_ready3), .d_rdata(d_rdata3),
    .m_address(m_address3), .m_o_data(m_o_data3), .m_wren(m_wren3), .m_i_data(m_i_data3)
  );

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    c_req = 1'b0; d_req = 1'b0; c_wren = 1'b0; d_wren = 1'b0;
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    logic [47:0] v0, v3;
    reset = 1'b1;
    tick();
    v0 = {m_address0, m_o_data0, m_wren0, c_ready0, d_ready0, c_rdata0, d_rdata0};
    v3 = {m_address3, m_o_data3, m_wren3, c_ready3, d_ready3, c_rdata3, d_rdata3};
    checks++;
    if (v0 !== 48'h0) begin errors++; $display("FAIL reset_dut0 got %h want 0", v0); end
    checks++;
    if (v3 !== 48'h0) begin errors++; $display("FAIL reset_dut3 got %h want 0", v3); end
    reset = 1'b0;
  endtask

  task automatic test_cpu_read();
    apply_reset();
    c_address = 16'h1234; c_wren = 1'b0; c_req = 1'b1;
    tick();
    checks++;
    if (m_address0 !== 16'h1234 || c_ready0 !== 1'b0) begin
      errors++; $display("FAIL cpu_read_access addr=%h rdy=%b want 1234/0", m_address0, c_ready0);
    end
    tick();
    checks++;
    if (c_ready0 !== 1'b1 || d_ready0 !== 1'b0 || c_rdata0 !== 8'hA5) begin
      errors++; $display("FAIL cpu_read_done c_rdy=%b d_rdy=%b rdata=%h want 1/0/a5", c_ready0, d_ready0, c_rdata0);
    end
    c_req = 1'b0;
    tick();
    checks++;
    if (c_ready0 !== 1'b0) begin errors++; $display("FAIL cpu_read_pulse_width c_ready=%b want 0", c_ready0); end
  endtask

  task automatic test_dma_write_wait3();
    int wren_cnt = 0, rdy_at = -1, rdy_cnt = 0;
    logic bad_data = 1'b0, c_seen = 1'b0;
    apply_reset();
    d_address = 16'hFFFF; d_data = 8'h3C; d_wren = 1'b1; d_req = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (m_wren3) begin
        wren_cnt++;
        if (m_o_data3 !== 8'h3C || m_address3 !== 16'hFFFF || i != 1) bad_data = 1'b1;
      end
      if (d_ready3) begin rdy_cnt++; rdy_at = i; d_req = 1'b0; end
      if (c_ready3) c_seen = 1'b1;
    end
    d_wren = 1'b0;
    checks++;
    if (wren_cnt != 1 || bad_data) begin
      errors++; $display("FAIL dma_write_strobe count=%0d bad=%b want 1/0", wren_cnt, bad_data);
    end
    checks++;
    if (rdy_cnt != 1 || rdy_at != 5) begin
      errors++; $display("FAIL dma_write_ready count=%0d at=%0d want 1 at 5", rdy_cnt, rdy_at);
    end
    checks++;
    if (c_seen || d_rdata3 !== 8'h00) begin
      errors++; $display("FAIL dma_write_side c_ready_seen=%b d_rdata=%h want 0/00", c_seen, d_rdata3);
    end
  endtask

  task automatic test_contention();
    @(negedge clk);
    reset = 1'b1;
    tick(); tick();
    c_address = 16'h0010; d_address = 16'h0020; c_wren = 1'b0; d_wren = 1'b0;
    c_req = 1'b1; d_req = 1'b1;
    reset = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      logic ec, ed;
      tick();
      ec = (i % 6 == 2);
      ed = (i % 6 == 5);
      checks++;
      if (c_ready0 !== ec || d_ready0 !== ed) begin
        errors++; $display("FAIL contention_ready cyc=%0d got c=%b d=%b want c=%b d=%b", i, c_ready0, d_ready0, ec, ed);
      end
      if (i == 1 || i == 4) begin
        checks++;
        if (m_address0 !== (i == 1 ? 16'h0010 : 16'h0020)) begin
          errors++; $display("FAIL contention_grant cyc=%0d m_address=%h", i, m_address0);
        end
      end
    end
    checks++;
    if (c_rdata0 !== 8'h4A || d_rdata0 !== 8'h7A) begin
      errors++; $display("FAIL contention_rdata c=%h d=%h want 4a/7a", c_rdata0, d_rdata0);
    end
    c_req = 1'b0; d_req = 1'b0;
  endtask

  task automatic test_mid_reset();
    logic [47:0] v3;
    logic bad = 1'b0;
    apply_reset();
    c_address = 16'h5555; c_data = 8'h77; c_wren = 1'b1; c_req = 1'b1;
    tick();
    checks++;
    if (m_wren3 !== 1'b1) begin errors++; $display("FAIL midreset_strobe m_wren=%b want 1", m_wren3); end
    tick();
    reset = 1'b1;
    #1;
    v3 = {m_address3, m_o_data3, m_wren3, c_ready3, d_ready3, c_rdata3, d_rdata3};
    checks++;
    if (v3 !== 48'h0) begin errors++; $display("FAIL midreset_async got %h want 0", v3); end
    c_req = 1'b0; c_wren = 1'b0;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (m_wren3 || c_ready3 || d_ready3) bad = 1'b1;
    end
    checks++;
    if (bad) begin errors++; $display("FAIL midreset_quiet saw wren/ready got 1 want 0"); end
  endtask

  task automatic test_held_request();
    apply_reset();
    c_address = 16'h0100; c_wren = 1'b0; c_req = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      logic ec;
      tick();
      ec = (i == 2 || i == 5);
      checks++;
      if (c_ready0 !== ec) begin
        errors++; $display("FAIL held_req cyc=%0d c_ready=%b want %b", i, c_ready0, ec);
      end
    end
    c_req = 1'b0;
  endtask

  task automatic test_req_drop();
    int pulses = 0;
    apply_reset();
    c_address = 16'h0200; c_wren = 1'b0; c_req = 1'b1;
    tick();
    c_req = 1'b0;
    tick();
    checks++;
    if (c_ready0 !== 1'b1 || c_rdata0 !== 8'h58) begin
      errors++; $display("FAIL req_drop_done c_ready=%b rdata=%h want 1/58", c_ready0, c_rdata0);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      if (c_ready0) pulses++;
    end
    checks++;
    if (pulses != 0) begin errors++; $display("FAIL req_drop_extra pulses=%0d want 0", pulses); end
  endtask

  initial begin
    test_reset();
    test_cpu_read();
    test_dma_write_wait3();
    test_contention();
    test_mid_reset();
    test_held_request();
    test_req_drop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter WAIT, default 0, meaning extra memory wait cycles per access, legal range 0..7.
REQ-002 SHALL have port clock, input, 1, the single system clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port c_req, input, 1, CPU access request.
REQ-005 SHALL have port c_wren, input, 1, CPU request is a write (1) or a read (0).
REQ-006 SHALL have port c_address, input, 16, CPU byte address.
REQ-007 SHALL have port c_data, input, 8, CPU write data.
REQ-008 SHALL have port c_ready, output, 1, CPU access complete.
REQ-009 SHALL have port c_rdata, output, 8, CPU read data.
REQ-010 SHALL have ports d_req, d_wren, d_address, d_data, d_ready and d_rdata with the same directions, widths and meanings for the DMA requester.
REQ-011 SHALL have port m_address, output, 16, memory address.
REQ-012 SHALL have port m_o_data, output, 8, memory write data.
REQ-013 SHALL have port m_wren, output, 1, memory write strobe.
REQ-014 SHALL have port m_i_data, input, 8, memory read data, valid one clock after the address is registered.

Function
REQ-015 SHALL implement states IDLE, ACCESS, WAIT and DONE.
REQ-016 SHALL, in IDLE with any request sampled, latch the grantee's address, data and wren into m_address, m_o_data and an internal write flag, record the grantee, and enter ACCESS.
REQ-017 SHALL stay in IDLE with all m_* outputs holding their previous values when no request is sampled.
REQ-018 SHALL grant round-robin: if both requests are sampled together, grant the port not granted last; a single request is granted immediately.
REQ-019 SHALL assert m_wren only during the single ACCESS cycle of a write.
REQ-020 SHALL go from ACCESS to DONE when WAIT=0, else load a 3-bit counter with WAIT and enter WAIT.
REQ-021 SHALL decrement the counter in WAIT and enter DONE on the edge where the counter equals 1.
REQ-022 SHALL, on the edge entering DONE, capture m_i_data into the grantee's rdata register for reads; rdata is unchanged for writes.
REQ-023 SHALL assert the grantee's ready for exactly the one DONE cycle; the other port's ready stays 0.
REQ-024 SHALL return from DONE to IDLE unconditionally.
REQ-025 SHALL give a request sampled in IDLE at edge k a ready high in the cycle following edge k+1+WAIT, which is k+2 for WAIT=0.
REQ-026 SHALL require requesters to hold req, address, data and wren stable until ready.
REQ-027 SHALL ignore a req drop during ACCESS, WAIT or DONE; the access completes.
REQ-028 SHALL treat a req still high at the IDLE edge after DONE as a new access, so a requester drops req in its ready cycle.
REQ-029 SHALL never interleave accesses; a losing requester waits, and back-to-back contention alternates CPU/DMA with no starvation.
REQ-030 SHALL let m_address wrap naturally within 16 bits, with no address arithmetic inside the block.

Reset
REQ-031 SHALL, on reset assertion at any time including mid-access, immediately force state IDLE, m_wren 0, c_ready 0, d_ready 0, m_address 0, m_o_data 0, c_rdata 0, d_rdata 0, counter 0, and last-granted = DMA.
REQ-032 SHALL make an aborted access produce no ready pulse and no further write strobe.
REQ-033 SHALL give the CPU first priority after reset release.

Verification
REQ-034 SHALL verify a CPU read with WAIT=0: c_address=16'h1234 with memory holding 8'hA5 -> m_address=16'h1234 one cycle after sampling, c_ready pulses one cycle at k+2, and c_rdata=8'hA5.
REQ-035 SHALL verify a DMA write with WAIT=3: d_address=16'hFFFF, d_data=8'h3C -> m_wren high exactly one cycle with m_o_data=8'h3C, and d_ready pulses at k+5.
REQ-036 SHALL verify contention: c_req and d_req held continuously from reset release -> grants run CPU, DMA, CPU, DMA, with each ready pulse 3 cycles apart and no cycle overlap.
REQ-037 SHALL verify a mid-access reset: reset asserted during WAIT of a write -> outputs immediately at reset values, no ready, and m_wren stays 0.
REQ-038 SHALL verify a held request: c_req kept high through c_ready -> a second access starts at the next IDLE edge, with ready pulses 3 cycles apart for WAIT=0.
REQ-039 SHALL verify a request drop: c_req dropped in the ACCESS cycle -> access still completes and c_ready still pulses once.
